mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data RAM between the CPU fetch stage (read-only) and the MEM stage (read/write, byte-select).
- Sequences each RAM access through a small FSM, returns data with a one-cycle ack pulse, and raises a stall request to the pipeline controller while any requester is waiting.
- Sits between the openmips core and the ram instance inside top.

Parameters:
- ADDR_W, 32, byte-address width from the core
- DATA_W, 32, data word width
- RAM_LATENCY, 1, cycles from ram_ce high to ram_rdata valid (legal range 1..7)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low: when rst is 0 at a rising edge of clk, the block resets
- i_req  input  1  fetch request, level, held until i_ack
- i_addr  input  ADDR_W  fetch byte address
- i_rdata  output  DATA_W  fetched word, valid when i_ack=1
- i_ack  output  1  one-cycle completion pulse to fetch
- d_req  input  1  data request, level, held until d_ack
- d_we  input  1  1=write, 0=read
- d_sel  input  DATA_W/8  byte enables for writes
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  DATA_W  write data
- d_rdata  output  DATA_W  read word, valid when d_ack=1
- d_ack  output  1  one-cycle completion pulse to data
- ram_ce  output  1  RAM access strobe, one cycle per access
- ram_we  output  1  RAM write enable, qualified by ram_ce
- ram_sel  output  DATA_W/8  RAM byte enables
- ram_addr  output  ADDR_W-2  RAM word address = addr[ADDR_W-1:2]
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data
- stall_req  output  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational

Behaviour:
- Reset values: all registered outputs 0; state IDLE; last_grant=FETCH; wait counter 0.
- Requester handshake: req, addr, we, sel and wdata are held stable from assertion until the ack cycle. The requester may drop req in the ack cycle or keep it high for a new access.
- FSM states:
  - IDLE: if any req is pending, latch the winner's fields, go to ACCESS.
  - ACCESS: ram_ce=1 for exactly one cycle, driven from latched fields. ram_we=d_we for data, 0 for fetch. ram_sel=d_sel for data, all-ones for fetch. Load counter with RAM_LATENCY-1, go to WAIT.
  - WAIT: decrement the counter. At 0, capture ram_rdata into the winner's rdata register and go to RESP. When RAM_LATENCY=1, WAIT lasts one cycle.
  - RESP: winner's ack=1 for one cycle. Only the other requester may be granted directly (RESP to ACCESS); otherwise go to IDLE.
- Priority on a simultaneous request: data wins, unless last_grant=DATA and i_req=1; then fetch wins. This is alternating under contention, so there is no starvation. last_grant updates at each grant.
- Latency: req first seen in IDLE at cycle N; ram_ce at N+1; ack at N+2+RAM_LATENCY (N+3 with the default).
- Writes follow the same timing. d_rdata on a write ack is don't-care; the block holds its previous value.
- rdata registers hold their value until the next capture for that port.
- ram_we, ram_sel, ram_addr and ram_wdata are 0 whenever ram_ce=0.
- Req dropped before ack (protocol violation): the RAM access in flight completes and the ack is suppressed if req=0 in the RESP cycle.
- Reset mid-transaction: the access is abandoned with no ack. All outputs follow the reset values on the next edge.
- Address low 2 bits are ignored (no misalignment trap here).

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3
  - grant encoding: FETCH=1'b0, DATA=1'b1
  - default widths
- No sub-module. The FSM, the latch registers and the counter fit in one module.

Test Plan:
- Single fetch: after reset release, i_req=1 with i_addr=0x0000_0008 and RAM word 2 = 0x3401_1100 → ram_ce at N+1 with ram_addr=2; i_ack one cycle at N+3; i_rdata=0x3401_1100; stall_req high until the ack cycle.
- Byte write: d_req with d_we=1, d_sel=4'b0010, d_addr=0x0C, d_wdata=0x0000_AB00 → ram_we=1, ram_sel=0010, ram_addr=3 for one cycle; d_ack at N+3; i_ack stays 0.
- Contention: i_req and d_req rise together → data is served first (d_ack at N+3), then fetch with RESP→ACCESS direct (i_ack at N+6). Both held continuously → grants alternate D, I, D, I.
- Latency parameter: RAM_LATENCY=3 → ack at N+5; ram_ce is high for one cycle only.
- Reset in WAIT: rst=0 during WAIT → next cycle all outputs 0 with no ack; after rst=1, a re-request completes normally.
- Early drop: d_req deasserted during WAIT → no d_ack; the FSM returns to IDLE after RESP and a pending i_req is then served.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and default widths for mem_port_arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_RAM_LATENCY = 1;
  // Wide enough to hold RAM_LATENCY-1 for the full 1..7 latency range
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported RAM between CPU fetch and MEM stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [ADDR_W-3:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                stall_req
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            winner_q, winner_d;
  grant_e            grant_who;
  logic              grant_go;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_ack, data_ack;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  // Ack is withheld if the requester dropped req while its access was in flight
  assign fetch_ack = (state_q == RESP) && (winner_q == FETCH) && i_req;
  assign data_ack  = (state_q == RESP) && (winner_q == DATA)  && d_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= FETCH;
      winner_q     <= FETCH;
      addr_q       <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_d        = cnt_q;
    grant_go     = 1'b0;
    grant_who    = FETCH;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_go = 1'b1;
          // Data normally wins; fetch takes its turn right after a data grant
          if (last_grant_q == DATA && i_req) grant_who = FETCH;
          else if (d_req)                    grant_who = DATA;
          else                               grant_who = FETCH;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (winner_q == FETCH) i_rdata_d = ram_rdata;
          else if (!we_q)        d_rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (data_ack && i_req) begin
          grant_go  = 1'b1;
          grant_who = FETCH;
        end else if (fetch_ack && d_req) begin
          grant_go  = 1'b1;
          grant_who = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_go) begin
      state_d      = ACCESS;
      winner_d     = grant_who;
      last_grant_d = grant_who;
      if (grant_who == DATA) begin
        addr_d  = d_addr[ADDR_W-1:2];
        we_d    = d_we;
        sel_d   = d_sel;
        wdata_d = d_wdata;
      end else begin
        addr_d  = i_addr[ADDR_W-1:2];
        we_d    = 1'b0;
        sel_d   = '1;
        wdata_d = '0;
      end
    end
  end

  assign ram_ce    = (state_q == ACCESS);
  assign ram_we    = ram_ce & we_q;
  assign ram_sel   = ram_ce ? sel_q   : '0;
  assign ram_addr  = ram_ce ? addr_q  : '0;
  assign ram_wdata = ram_ce ? wdata_q : '0;

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = fetch_ack;
  assign d_ack     = data_ack;
  assign stall_req = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT   = 1;
  localparam int LAT3  = 3;
  localparam int BOUND = 2 * (LAT + 2) + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic        i_ack, d_ack, ram_ce, ram_we, stall_req;
  logic [3:0]  ram_sel;
  logic [29:0] ram_addr;

  logic        i_req3 = 0, zero1 = 0;
  logic [31:0] i_addr3 = '0, zero32 = '0;
  logic [3:0]  zero4 = '0;
  logic [31:0] i_rdata3, d_rdata3, ram_wdata3, ram_rdata3;
  logic        i_ack3, d_ack3, ram_ce3, ram_we3, stall3;
  logic [3:0]  ram_sel3;
  logic [29:0] ram_addr3;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] p3 [0:2];
  logic        fill_en = 0, poke_en = 0;
  logic [7:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  int checks = 0, errors = 0, cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_req(stall_req)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ack(i_ack3),
    .d_req(zero1), .d_we(zero1), .d_sel(zero4), .d_addr(zero32), .d_wdata(zero32),
    .d_rdata(d_rdata3), .d_ack(d_ack3),
    .ram_ce(ram_ce3), .ram_we(ram_we3), .ram_sel(ram_sel3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .stall_req(stall3)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM with one-cycle read latency; garbage when no read was issued
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (ram_ce && ram_we) begin
      mem[ram_addr[7:0]] <= merge(mem[ram_addr[7:0]], ram_wdata, ram_sel);
    end
    ram_rdata <= (ram_ce && !ram_we) ? mem[ram_addr[7:0]] : 32'hDEAD_BEEF;
  end

  // Three-cycle RAM whose contents are a fixed function of the word address
  always @(posedge clk) begin
    p3[0] <= (ram_ce3 && !ram_we3) ? {16'hC0DE, 2'b00, ram_addr3[13:0]} : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_rdata3 = p3[2];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    ref_mem[a] = v;
    poke_addr  = 8'(a);
    poke_data  = v;
    poke_en    = 1'b1;
    tick();
    poke_en    = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; i_req = 0; d_req = 0;
    repeat (3) tick();
    checks++;
    if ({ram_ce, ram_we, ram_sel, ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_ram ce=%b we=%b sel=%h addr=%h wdata=%h exp all 0",
                         ram_ce, ram_we, ram_sel, ram_addr, ram_wdata);
    end
    checks++;
    if ({i_ack, d_ack, stall_req, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_port i_ack=%b d_ack=%b stall=%b i_rdata=%h d_rdata=%h exp all 0",
                         i_ack, d_ack, stall_req, i_rdata, d_rdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch;
    poke(2, 32'h3401_1100);
    i_addr = 32'h0000_0008; i_req = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin errors++; $display("FAIL fetch_stall_n got %b exp 1", stall_req); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (ram_ce !== (k == 1)) begin errors++; $display("FAIL fetch_ce k=%0d got %b exp %b", k, ram_ce, k == 1); end
      if (k == 1) begin
        checks++;
        if (ram_addr !== 30'd2 || ram_sel !== 4'hF || ram_we !== 1'b0) begin
          errors++; $display("FAIL fetch_ram addr=%h sel=%h we=%b exp 2/f/0", ram_addr, ram_sel, ram_we);
        end
      end
      checks++;
      if (i_ack !== (k == 3) || stall_req !== (k != 3)) begin
        errors++; $display("FAIL fetch_ack k=%0d ack=%b stall=%b exp %b/%b", k, i_ack, stall_req, k == 3, k != 3);
      end
    end
    checks++;
    if (i_rdata !== 32'h3401_1100) begin errors++; $display("FAIL fetch_data got %h exp 34011100", i_rdata); end
    i_req = 1'b0;
    tick();
    checks++;
    if (i_ack !== 1'b0 || i_rdata !== 32'h3401_1100) begin
      errors++; $display("FAIL fetch_hold ack=%b rdata=%h exp 0/34011100", i_ack, i_rdata);
    end
  endtask

  task automatic test_byte_write;
    poke(3, 32'h1122_3344);
    d_we = 1'b1; d_sel = 4'b0010; d_addr = 32'h0000_000C; d_wdata = 32'h0000_AB00; d_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (ram_ce !== (k == 1) || ram_we !== (k == 1)) begin
        errors++; $display("FAIL wr_ce k=%0d ce=%b we=%b exp %b", k, ram_ce, ram_we, k == 1);
      end
      checks++;
      if (k == 1 && (ram_sel !== 4'b0010 || ram_addr !== 30'd3 || ram_wdata !== 32'h0000_AB00)) begin
        errors++; $display("FAIL wr_fields sel=%b addr=%h wdata=%h exp 0010/3/0000ab00", ram_sel, ram_addr, ram_wdata);
      end else if (k != 1 && {ram_sel, ram_addr, ram_wdata} !== '0) begin
        errors++; $display("FAIL wr_idle_zero k=%0d sel=%b addr=%h wdata=%h exp 0", k, ram_sel, ram_addr, ram_wdata);
      end
      checks++;
      if (d_ack !== (k == 3) || i_ack !== 1'b0) begin
        errors++; $display("FAIL wr_ack k=%0d d_ack=%b i_ack=%b exp %b/0", k, d_ack, i_ack, k == 3);
      end
    end
    checks++;
    if (d_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_hold got %h exp 0", d_rdata); end
    ref_mem[3] = merge(32'h1122_3344, 32'h0000_AB00, 4'b0010);
    d_we = 1'b0; d_sel = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (d_ack !== (k == 4)) begin errors++; $display("FAIL rdback_ack k=%0d got %b exp %b", k, d_ack, k == 4); end
    end
    checks++;
    if (d_rdata !== ref_mem[3]) begin errors++; $display("FAIL rdback_data got %h exp %h", d_rdata, ref_mem[3]); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    logic [3:0] es;
    do_reset();
    i_addr = 32'h8; d_addr = 32'hC; d_we = 1'b0; d_sel = 4'b0101;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      es = (k % 6 == 1) ? 4'b0101 : 4'b1111;
      checks++;
      if (ram_ce !== (k % 3 == 1)) begin errors++; $display("FAIL cont_ce k=%0d got %b exp %b", k, ram_ce, k % 3 == 1); end
      if (ram_ce) begin
        checks++;
        if (ram_sel !== es) begin errors++; $display("FAIL cont_grant k=%0d sel=%b exp %b", k, ram_sel, es); end
      end
      checks++;
      if (d_ack !== (k % 6 == 3) || i_ack !== (k % 6 == 0)) begin
        errors++; $display("FAIL cont_ack k=%0d d=%b i=%b exp %b/%b", k, d_ack, i_ack, k % 6 == 3, k % 6 == 0);
      end
      if (d_ack && d_rdata !== ref_mem[3]) begin
        errors++; $display("FAIL cont_ddata got %h exp %h", d_rdata, ref_mem[3]);
      end
      if (i_ack && i_rdata !== ref_mem[2]) begin
        errors++; $display("FAIL cont_idata got %h exp %h", i_rdata, ref_mem[2]);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    checks++;
    if (ram_ce !== 1'b0) begin errors++; $display("FAIL cont_idle ce=%b exp 0", ram_ce); end
  endtask

  task automatic test_latency;
    i_addr3 = 32'h10; i_req3 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (ram_ce3 !== (k == 1) || i_ack3 !== (k == 5)) begin
        errors++; $display("FAIL lat3 k=%0d ce=%b ack=%b exp %b/%b", k, ram_ce3, i_ack3, k == 1, k == 5);
      end
    end
    checks++;
    if (i_rdata3 !== 32'hC0DE_0004) begin errors++; $display("FAIL lat3_data got %h exp c0de0004", i_rdata3); end
    i_req3 = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait;
    d_addr = 32'h8; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    repeat (2) tick();
    rst = 1'b0; d_req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({ram_ce, d_ack, i_ack, stall_req, i_rdata, d_rdata} !== '0) begin
        errors++; $display("FAIL rstwait k=%0d ce=%b d_ack=%b i_ack=%b stall=%b i_rdata=%h d_rdata=%h exp 0",
                           k, ram_ce, d_ack, i_ack, stall_req, i_rdata, d_rdata);
      end
    end
    rst = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (d_ack !== (k == 3)) begin errors++; $display("FAIL rstwait_retry k=%0d got %b exp %b", k, d_ack, k == 3); end
    end
    checks++;
    if (d_rdata !== ref_mem[2]) begin errors++; $display("FAIL rstwait_data got %h exp %h", d_rdata, ref_mem[2]); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_early_drop;
    d_addr = 32'hC; d_we = 1'b0; d_sel = 4'hF; d_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (d_ack !== 1'b0 || ram_ce !== (k == 1 || k == 5) || i_ack !== (k == 7) || stall_req !== (k != 7)) begin
        errors++; $display("FAIL drop k=%0d d_ack=%b ce=%b i_ack=%b stall=%b exp 0/%b/%b/%b",
                           k, d_ack, ram_ce, i_ack, stall_req, k == 1 || k == 5, k == 7, k != 7);
      end
      if (k == 1) begin i_addr = 32'h8; i_req = 1'b1; end
      if (k == 2) d_req = 1'b0;
    end
    checks++;
    if (i_rdata !== ref_mem[2]) begin errors++; $display("FAIL drop_data got %h exp %h", i_rdata, ref_mem[2]); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_random;
    int last_ce, n_ce, n_ack, i_rise, d_rise;
    logic stop;
    last_ce = -100; n_ce = 0; n_ack = 0; i_rise = cyc; d_rise = cyc; stop = 1'b0;
    for (int n = 0; n < 1560; n++) begin
      if (n >= 1500) stop = 1'b1;
      if (stop && !i_req && !d_req) break;
      tick();
      if (ram_ce) begin
        last_ce = cyc; n_ce++;
      end else begin
        checks++;
        if ({ram_we, ram_sel, ram_addr, ram_wdata} !== '0) begin
          errors++; $display("FAIL rnd_idle_zero cyc=%0d we=%b sel=%b addr=%h wdata=%h exp 0",
                             cyc, ram_we, ram_sel, ram_addr, ram_wdata);
        end
      end
      checks++;
      if (i_ack && d_ack) begin errors++; $display("FAIL rnd_dual_ack cyc=%0d got 1/1 exp one", cyc); end
      if (i_ack) begin
        n_ack++;
        checks++;
        if (cyc != last_ce + 1 + LAT || cyc - i_rise > BOUND) begin
          errors++; $display("FAIL rnd_i_timing cyc=%0d ce=%0d rise=%0d exp ack at ce+%0d within %0d",
                             cyc, last_ce, i_rise, 1 + LAT, BOUND);
        end
        checks++;
        if (i_rdata !== ref_mem[i_addr[9:2]]) begin
          errors++; $display("FAIL rnd_i_data addr=%h got %h exp %h", i_addr, i_rdata, ref_mem[i_addr[9:2]]);
        end
      end
      if (d_ack) begin
        n_ack++;
        checks++;
        if (cyc != last_ce + 1 + LAT || cyc - d_rise > BOUND) begin
          errors++; $display("FAIL rnd_d_timing cyc=%0d ce=%0d rise=%0d exp ack at ce+%0d within %0d",
                             cyc, last_ce, d_rise, 1 + LAT, BOUND);
        end
        if (d_we) begin
          ref_mem[d_addr[9:2]] = merge(ref_mem[d_addr[9:2]], d_wdata, d_sel);
        end else begin
          checks++;
          if (d_rdata !== ref_mem[d_addr[9:2]]) begin
            errors++; $display("FAIL rnd_d_data addr=%h got %h exp %h", d_addr, d_rdata, ref_mem[d_addr[9:2]]);
          end
        end
      end
      if (i_req && i_ack) begin
        if (stop || $urandom_range(1) == 0) i_req = 1'b0;
        else begin i_addr = 32'($urandom_range(255)); i_rise = cyc; end
      end else if (!i_req && !stop && $urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = 32'($urandom_range(255)); i_rise = cyc;
      end
      if ((d_req && d_ack) || (!d_req && !stop && $urandom_range(2) == 0)) begin
        if (d_req && (stop || $urandom_range(1) == 0)) d_req = 1'b0;
        else begin
          d_req = 1'b1; d_we = 1'($urandom_range(1)); d_sel = 4'($urandom);
          d_addr = 32'($urandom_range(255)); d_wdata = $urandom; d_rise = cyc;
        end
      end
    end
    checks++;
    if (i_req || d_req) begin errors++; $display("FAIL rnd_drain i_req=%b d_req=%b exp 0/0", i_req, d_req); end
    checks++;
    if (n_ack != n_ce || n_ack == 0) begin errors++; $display("FAIL rnd_count acks=%0d ce=%0d exp equal, nonzero", n_ack, n_ce); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
    test_reset();
    test_single_fetch();
    test_byte_write();
    test_contention();
    test_latency();
    test_reset_in_wait();
    test_early_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached at cyc=%0d exp finish before", cyc);
    $fatal(1, "timeout");
  end

endmodule
